// File: rtl/msd_pkg.sv
// Shared constants and width helper for the multi-channel sticky detector.
package msd_pkg;

    localparam int DEF_CH      = 4;
    localparam int DEF_RUN_LEN = 1;
    localparam int DEF_TS_W    = 16;

    // clog2 that never returns 0, so a 1-entry range still gets a 1-bit field
    function automatic int safeClog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/msd_chan.sv
// One detector channel: counts consecutive enabled 1s and latches a sticky hit.
module msd_chan
    import msd_pkg::*;
#(
    parameter int RUN_LEN = DEF_RUN_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din_i,
    input  logic mask_i,
    output logic complete_o,
    output logic hit_o
);

    localparam int RW = safeClog2(RUN_LEN + 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(RUN_LEN);
    localparam logic [RW-1:0] RUN_LAST = RW'(RUN_LEN - 1);

    logic [RW-1:0] run_q, run_d;
    logic          hit_q, hit_d;
    logic          complete;

    // A re-arm in the same cycle always wins over a completing run
    always_comb begin
        complete = mask_i & din_i & (run_q == RUN_LAST) & ~clr;
        run_d    = '0;
        if (mask_i && din_i) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        end
        hit_d = hit_q | complete;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            run_q <= '0;
            hit_q <= 1'b0;
        end else begin
            run_q <= run_d;
            hit_q <= hit_d;
        end
    end

    assign complete_o = complete;
    assign hit_o      = hit_q;

endmodule

// File: rtl/multi_sticky_detector.sv
// Multi-channel sticky run detector with first-event channel/timestamp capture.
module multi_sticky_detector
    import msd_pkg::*;
#(
    parameter int CH      = DEF_CH,
    parameter int RUN_LEN = DEF_RUN_LEN,
    parameter int TS_W    = DEF_TS_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CH-1:0]             din,
    input  logic [CH-1:0]             mask,
    input  logic                      clr,
    output logic [CH-1:0]             hit,
    output logic                      any_hit,
    output logic                      hit_pulse,
    output logic                      first_valid,
    output logic [safeClog2(CH)-1:0]  first_ch,
    output logic [TS_W-1:0]           first_ts
);

    localparam int CW = safeClog2(CH);

    logic [CH-1:0]   complete;
    logic [CH-1:0]   hitNow;
    logic [CH-1:0]   hitNext;
    logic [CW-1:0]   encIdx;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            any_hit_q, any_hit_d;
    logic            hit_pulse_q, hit_pulse_d;
    logic            first_valid_q, first_valid_d;
    logic [CW-1:0]   first_ch_q, first_ch_d;
    logic [TS_W-1:0] first_ts_q, first_ts_d;

    for (genvar g = 0; g < CH; g++) begin : g_chan
        msd_chan #(
            .RUN_LEN(RUN_LEN)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .din_i     (din[g]),
            .mask_i    (mask[g]),
            .complete_o(complete[g]),
            .hit_o     (hitNow[g])
        );
    end

    // Scan from the top so the lowest completing index ends up winning
    always_comb begin
        encIdx = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (complete[i]) begin
                encIdx = CW'(i);
            end
        end
    end

    always_comb begin
        hitNext       = hitNow | complete;
        ts_d          = (ts_q == '1) ? ts_q : ts_q + 1'b1;
        any_hit_d     = |hitNext;
        hit_pulse_d   = (|hitNext) & ~(|hitNow);
        first_valid_d = first_valid_q;
        first_ch_d    = first_ch_q;
        first_ts_d    = first_ts_q;
        if (!first_valid_q && (|complete)) begin
            first_valid_d = 1'b1;
            first_ch_d    = encIdx;
            first_ts_d    = ts_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ts_q          <= '0;
            any_hit_q     <= 1'b0;
            hit_pulse_q   <= 1'b0;
            first_valid_q <= 1'b0;
            first_ch_q    <= '0;
            first_ts_q    <= '0;
        end else begin
            ts_q          <= ts_d;
            any_hit_q     <= any_hit_d;
            hit_pulse_q   <= hit_pulse_d;
            first_valid_q <= first_valid_d;
            first_ch_q    <= first_ch_d;
            first_ts_q    <= first_ts_d;
        end
    end

    assign hit         = hitNow;
    assign any_hit     = any_hit_q;
    assign hit_pulse   = hit_pulse_q;
    assign first_valid = first_valid_q;
    assign first_ch    = first_ch_q;
    assign first_ts    = first_ts_q;

endmodule

// File: tb/tb_multi_sticky_detector.sv
// Scoreboard bench: instance A uses defaults, instance B uses RUN_LEN=3 and a 4-bit timestamp.
module tb_multi_sticky_detector;

    typedef struct {
        logic [1:0][3:0]  hit;
        logic [1:0]       any;
        logic [1:0]       pulse;
        logic [1:0]       fv;
        logic [1:0][1:0]  fch;
        logic [1:0][15:0] fts;
    } expT;

    logic        clk = 1'b0;
    logic        rstN;
    logic        clrIn;
    logic [3:0]  din;
    logic [3:0]  mask;

    logic [3:0]  hitA, hitB;
    logic        anyA, anyB, pulseA, pulseB, fvA, fvB;
    logic [1:0]  fchA, fchB;
    logic [15:0] ftsA;
    logic [3:0]  ftsB;

    int vectors = 0;
    int miscompares = 0;

    int         mRun [2][4];
    logic [3:0] mHit [2];
    int         mTs [2];
    logic       mFv [2];
    logic       mPulse [2];
    int         mFch [2];
    int         mFts [2];
    int         runLenTab [2] = '{1, 3};
    int         tsMaxTab [2]  = '{65535, 15};

    expT expQ [$];

    multi_sticky_detector dutA (
        .clk(clk), .rst_n(rstN), .din(din), .mask(mask), .clr(clrIn),
        .hit(hitA), .any_hit(anyA), .hit_pulse(pulseA), .first_valid(fvA),
        .first_ch(fchA), .first_ts(ftsA)
    );

    multi_sticky_detector #(.CH(4), .RUN_LEN(3), .TS_W(4)) dutB (
        .clk(clk), .rst_n(rstN), .din(din), .mask(mask), .clr(clrIn),
        .hit(hitB), .any_hit(anyB), .hit_pulse(pulseB), .first_valid(fvB),
        .first_ch(fchB), .first_ts(ftsB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioural reference for one instance, advanced once per clock edge
    task automatic stepModel(input int k);
        logic [3:0] comp;
        bit         found;
        if (!rstN || clrIn) begin
            for (int i = 0; i < 4; i++) mRun[k][i] = 0;
            mHit[k] = '0; mTs[k] = 0; mFv[k] = 1'b0; mFch[k] = 0; mFts[k] = 0; mPulse[k] = 1'b0;
        end else begin
            comp = '0;
            for (int i = 0; i < 4; i++) begin
                if (mask[i] && din[i]) begin
                    if (mRun[k][i] == runLenTab[k] - 1) comp[i] = 1'b1;
                    if (mRun[k][i] < runLenTab[k]) mRun[k][i]++;
                end else begin
                    mRun[k][i] = 0;
                end
            end
            mPulse[k] = (mHit[k] == 4'b0) && ((mHit[k] | comp) != 4'b0);
            if (!mFv[k] && comp != 4'b0) begin
                mFv[k] = 1'b1;
                mFts[k] = mTs[k];
                found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (comp[i] && !found) begin
                        mFch[k] = i;
                        found = 1'b1;
                    end
                end
            end
            mHit[k] = mHit[k] | comp;
            if (mTs[k] < tsMaxTab[k]) mTs[k]++;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic [3:0] d, input logic [3:0] m);
        expT e;
        rstN = r; clrIn = c; din = d; mask = m;
        stepModel(0);
        stepModel(1);
        for (int k = 0; k < 2; k++) begin
            e.hit[k]   = mHit[k];
            e.any[k]   = (mHit[k] != 4'b0);
            e.pulse[k] = mPulse[k];
            e.fv[k]    = mFv[k];
            e.fch[k]   = 2'(mFch[k]);
            e.fts[k]   = 16'(mFts[k]);
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkOutput("hitA", hitA, e.hit[0]);
        checkOutput("anyA", anyA, e.any[0]);
        checkOutput("pulseA", pulseA, e.pulse[0]);
        checkOutput("fvA", fvA, e.fv[0]);
        checkOutput("fchA", fchA, e.fch[0]);
        checkOutput("ftsA", ftsA, e.fts[0]);
        checkOutput("hitB", hitB, e.hit[1]);
        checkOutput("anyB", anyB, e.any[1]);
        checkOutput("pulseB", pulseB, e.pulse[1]);
        checkOutput("fvB", fvB, e.fv[1]);
        checkOutput("fchB", fchB, e.fch[1]);
        checkOutput("ftsB", ftsB, e.fts[1]);
    endtask

    task automatic idle(input int n, input logic [3:0] d, input logic [3:0] m);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, d, m);
    endtask

    initial begin
        rstN = 1'b0; clrIn = 1'b0; din = '0; mask = '0;

        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF);
        checkOutput("reset_hitA", hitA, 4'h0);
        checkOutput("reset_fvB", fvB, 1'b0);

        // Single-cycle first 1 on channel 2 after five quiet cycles
        idle(5, 4'h0, 4'hF);
        applyStimulus(1'b1, 1'b0, 4'b0100, 4'hF);
        checkOutput("tp1_hitA", hitA, 4'b0100);
        checkOutput("tp1_pulseA", pulseA, 1'b1);
        checkOutput("tp1_fchA", fchA, 2);
        checkOutput("tp1_ftsA", ftsA, 5);
        idle(20, 4'h0, 4'hF);
        checkOutput("tp1_hold_hitA", hitA, 4'b0100);
        checkOutput("tp1_pulse_gone", pulseA, 1'b0);

        // Broken and completed run on channel 0
        applyStimulus(1'b1, 1'b1, 4'h0, 4'hF);
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'hF);
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'hF);
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'hF);
        checkOutput("tp2_nohitB", hitB, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'hF);
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'hF);
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'hF);
        checkOutput("tp2_hitB", hitB, 4'b0001);
        checkOutput("tp2_pulseB", pulseB, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'hF);
        checkOutput("tp2_norepulseB", pulseB, 1'b0);

        // Simultaneous completion on channels 1 and 3
        applyStimulus(1'b1, 1'b1, 4'h0, 4'hF);
        idle(3, 4'b1010, 4'hF);
        checkOutput("tp3_hitB", hitB, 4'b1010);
        checkOutput("tp3_fchB", fchB, 1);
        idle(3, 4'b0001, 4'hF);
        checkOutput("tp3_hitB_late", hitB, 4'b1011);
        checkOutput("tp3_fchB_late", fchB, 1);

        // Masked channel 3, then mask drop after it has fired
        applyStimulus(1'b1, 1'b1, 4'h0, 4'hF);
        idle(10, 4'b1000, 4'b0111);
        checkOutput("tp4_maskedA", hitA, 4'h0);
        idle(3, 4'b1000, 4'hF);
        idle(3, 4'b0000, 4'b0111);
        checkOutput("tp4_stickyB", hitB, 4'b1000);

        // Re-arm wins over a completion on the same edge
        applyStimulus(1'b1, 1'b1, 4'h0, 4'hF);
        idle(2, 4'b0010, 4'hF);
        applyStimulus(1'b1, 1'b1, 4'b0010, 4'hF);
        checkOutput("tp5_clr_hitA", hitA, 4'h0);
        checkOutput("tp5_clr_hitB", hitB, 4'h0);
        checkOutput("tp5_clr_fvA", fvA, 1'b0);
        idle(4, 4'b0000, 4'hF);
        idle(3, 4'b0010, 4'hF);
        checkOutput("tp5_ftsA", ftsA, 4);
        checkOutput("tp5_ftsB", ftsB, 6);

        // Timestamp saturation on the 4-bit instance
        applyStimulus(1'b1, 1'b1, 4'h0, 4'hF);
        idle(20, 4'h0, 4'hF);
        idle(3, 4'hF, 4'hF);
        checkOutput("tp6_ftsA", ftsA, 20);
        checkOutput("tp6_ftsB", ftsB, 15);
        checkOutput("tp6_fchB", fchB, 0);

        // Reset in the middle of a run
        applyStimulus(1'b1, 1'b1, 4'h0, 4'hF);
        idle(2, 4'hF, 4'hF);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        checkOutput("tp7_rst_hitA", hitA, 4'h0);
        checkOutput("tp7_rst_anyA", anyA, 1'b0);
        idle(3, 4'hF, 4'hF);

        // Random traffic with occasional re-arm
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, ($urandom_range(0, 19) == 0), 4'($urandom), 4'($urandom_range(8, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
